// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client (icache/dcache) arbiter onto a single memory port.
//
// One request is in flight at a time.
//   IDLE      : grant a requester, latch its request, pulse its req_ready
//   ISSUE     : hold mem_req_* stable until mem_req_ready
//   WAIT_RESP : reads only; route mem_resp_* to the owner in the same cycle
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   ic_req_* / ic_resp_*         icache read-only client
//   dc_req_* / dc_resp_*         dcache client (dc_req_we != 0 means write)
//   mem_req_* / mem_resp_*       memory side
//   busy                         high whenever the FSM is not in IDLE
//
// Build option
//   ARB_ROUND_ROBIN_EN  : alternate the grant between clients when both
//                         request. Without it, dcache always wins.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ic_req_valid,
  input  logic [31:0] ic_req_addr,
  output logic        ic_req_ready,
  output logic        ic_resp_valid,
  output logic [31:0] ic_resp_data,
  input  logic        dc_req_valid,
  input  logic [31:0] dc_req_addr,
  input  logic [3:0]  dc_req_we,
  input  logic [31:0] dc_req_wdata,
  output logic        dc_req_ready,
  output logic        dc_resp_valid,
  output logic [31:0] dc_resp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_we,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t      state, state_nxt;
  logic        own_dc;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  we_q;
  logic        any_req, grant, grant_dc;

  assign any_req = ic_req_valid | dc_req_valid;
  // Grants are only issued while sitting in IDLE, so the cycle that returns
  // to IDLE can never grant. reset_n gates ready so nothing is accepted
  // while reset is held.
  assign grant   = reset_n && (state == IDLE) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dc;  // 1: dcache won the last grant; resets to icache

  assign grant_dc = dc_req_valid && (!ic_req_valid || !last_dc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   last_dc <= 1'b0;
    else if (grant) last_dc <= grant_dc;
  end
`else
  assign grant_dc = dc_req_valid;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_req)        state_nxt = ISSUE;
      ISSUE:     if (mem_req_ready)  state_nxt = (we_q != 4'b0000) ? IDLE : WAIT_RESP;
      WAIT_RESP: if (mem_resp_valid) state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Request capture; icache requests are always reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own_dc  <= 1'b0;
      addr_q  <= 32'h0;
      we_q    <= 4'h0;
      wdata_q <= 32'h0;
    end else if (grant) begin
      own_dc  <= grant_dc;
      addr_q  <= grant_dc ? dc_req_addr  : ic_req_addr;
      we_q    <= grant_dc ? dc_req_we    : 4'h0;
      wdata_q <= grant_dc ? dc_req_wdata : 32'h0;
    end
  end

  assign dc_req_ready  = grant &  grant_dc;
  assign ic_req_ready  = grant & ~grant_dc;

  assign mem_req_valid = (state == ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;

  // Responses outside WAIT_RESP are dropped.
  assign dc_resp_valid = (state == WAIT_RESP) && mem_resp_valid &&  own_dc;
  assign ic_resp_valid = (state == WAIT_RESP) && mem_resp_valid && !own_dc;
  assign dc_resp_data  = mem_resp_data;
  assign ic_resp_data  = mem_resp_data;

  assign busy = (state != IDLE);

endmodule
